// File: rtl/sensor_packet_assembler.sv
// sensor_packet_assembler
// Keeps the latest quaternion/gyro samples from two BNO085 decoders. On snap_req
// it freezes them into a 32-byte packet and streams it out with ready/valid,
// finishing with an XOR checksum byte.
module sensor_packet_assembler #(
    parameter logic [7:0] HEADER = 8'hAA,
    parameter int         SEQ_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s1_quat_valid,
    input  logic [63:0] s1_quat,
    input  logic        s1_gyro_valid,
    input  logic [47:0] s1_gyro,
    input  logic        s2_quat_valid,
    input  logic [63:0] s2_quat,
    input  logic        s2_gyro_valid,
    input  logic [47:0] s2_gyro,
    input  logic        snap_req,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        pkt_done
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [63:0]        r_s1_quat, r_s2_quat, r_snap_s1_quat, r_snap_s2_quat;
    logic [47:0]        r_s1_gyro, r_s2_gyro, r_snap_s1_gyro, r_snap_s2_gyro;
    // fresh bit order: {s2 gyro, s2 quat, s1 gyro, s1 quat}
    logic [3:0]         r_fresh, r_snap_fresh;
    logic [3:0]         w_valids;
    logic [4:0]         r_idx;
    logic [7:0]         r_chk;
    logic [SEQ_W-1:0]   r_seq;
    logic               r_pkt_done;

    logic               w_snap, w_accept, w_last;
    logic [255:0]       w_pkt;
    logic [7:0]         w_bytes [32];

    // Flag byte: seq in the upper nibble, fresh bits in [1:0].
    function automatic logic [7:0] flag_byte(input logic [SEQ_W-1:0] seq,
                                             input logic gyro_fresh,
                                             input logic quat_fresh);
        logic [7:0] s;
        s = 8'(seq);
        return {s[3:0], 2'b00, gyro_fresh, quat_fresh};
    endfunction

    assign w_valids = {s2_gyro_valid, s2_quat_valid, s1_gyro_valid, s1_quat_valid};
    assign pkt_done = r_pkt_done;

    // Packet image from the snapshot; the last byte is the running checksum,
    // which holds the XOR of bytes 0..30 by the time byte 31 is presented.
    always_comb begin
        w_pkt = {HEADER,
                 r_snap_s1_quat, r_snap_s1_gyro,
                 flag_byte(r_seq, r_snap_fresh[1], r_snap_fresh[0]),
                 r_snap_s2_quat, r_snap_s2_gyro,
                 flag_byte(r_seq, r_snap_fresh[3], r_snap_fresh[2]),
                 r_chk};
        for (int i = 0; i < 32; i++) begin
            w_bytes[i] = w_pkt[8*(31-i) +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; snap_req is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        busy        = 1'b0;
        w_snap      = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (snap_req) begin
                    w_snap      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = w_bytes[r_idx];
                w_accept = tx_ready;
                w_last   = tx_ready && (r_idx == 5'd31);
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Live samples, snapshot, byte index, checksum and sequence counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_quat      <= '0;
            r_s1_gyro      <= '0;
            r_s2_quat      <= '0;
            r_s2_gyro      <= '0;
            r_snap_s1_quat <= '0;
            r_snap_s1_gyro <= '0;
            r_snap_s2_quat <= '0;
            r_snap_s2_gyro <= '0;
            r_fresh        <= '0;
            r_snap_fresh   <= '0;
            r_idx          <= '0;
            r_chk          <= '0;
            r_seq          <= '0;
            r_pkt_done     <= 1'b0;
        end else begin
            if (s1_quat_valid) r_s1_quat <= s1_quat;
            if (s1_gyro_valid) r_s1_gyro <= s1_gyro;
            if (s2_quat_valid) r_s2_quat <= s2_quat;
            if (s2_gyro_valid) r_s2_gyro <= s2_gyro;

            // A strobe coinciding with a snapshot leaves its fresh bit set.
            if (w_snap) begin
                r_snap_s1_quat <= r_s1_quat;
                r_snap_s1_gyro <= r_s1_gyro;
                r_snap_s2_quat <= r_s2_quat;
                r_snap_s2_gyro <= r_s2_gyro;
                r_snap_fresh   <= r_fresh;
                r_fresh        <= w_valids;
                r_idx          <= '0;
                r_chk          <= '0;
            end else begin
                r_fresh <= r_fresh | w_valids;
            end

            if (w_accept) begin
                r_chk <= r_chk ^ tx_data;
                r_idx <= r_idx + 5'd1;
            end

            if (w_last) begin
                r_seq <= r_seq + {{(SEQ_W-1){1'b0}}, 1'b1};
            end

            r_pkt_done <= w_last;
        end
    end

endmodule
